// File: rtl/mix_columns_iter_pkg.sv
// GF(2^8) helpers, FSM state and mode encodings shared by the iterative
// MixColumns engine and its column unit.
package aes_mix_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mix_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // Inverse coefficients are built from the x2/x4/x8 chain.
    function automatic logic [7:0] gmul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gmulB(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gmulD(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gmulE(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// Input and output valid/ready channels of the MixColumns engine.
interface mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix_columns_iter_unit.sv
// One-column MixColumns / InvMixColumns, combinational. Byte a0 is col[31:24];
// the optional complement matches the round logic's inverted-data convention.
module mix_column_unit
    import aes_mix_pkg::*;
#(
    parameter bit INV_OUT = 1'b1
) (
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] mixed
);

    logic [3:0][7:0] a;
    logic [3:0][7:0] y;

    assign a = col;

    // Row r: c0*a[r] ^ c1*a[r+1] ^ c2*a[r+2] ^ c3*a[r+3]; a_k lives at a[3-k].
    always_comb begin
        y = '0;
        for (int r = 0; r < 4; r++) begin
            if (inv == MODE_INV) begin
                y[3-r] = gmulE(a[3-r])           ^ gmulB(a[3-((r+1)%4)]) ^
                         gmulD(a[3-((r+2)%4)])   ^ gmul9(a[3-((r+3)%4)]);
            end else begin
                y[3-r] = gmul2(a[3-r])           ^ gmul3(a[3-((r+1)%4)]) ^
                         a[3-((r+2)%4)]          ^ a[3-((r+3)%4)];
            end
        end
    end

    assign mixed = INV_OUT ? ~y : y;

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns / InvMixColumns engine: one 128-bit state in, mixed
// COLS_PER_CYCLE columns per cycle in place, registered result out.
module mix_columns_iter
    import aes_mix_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_OUT        = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mix_columns_iter_if.slave bus
);

    localparam int NCYC  = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mix_state_t               state;
    logic [CNT_W-1:0]         cnt;
    logic                     inv_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic [127:0]             out_data_q;
    // Word 3 is column 0 so the packed layout matches in_data directly.
    logic [3:0][31:0]         work;
    logic [3:0][31:0]         work_nxt;

    logic [COLS_PER_CYCLE-1:0][31:0] lane_col;
    logic [COLS_PER_CYCLE-1:0][31:0] lane_mix;
    logic [COLS_PER_CYCLE-1:0][1:0]  lane_word;

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
        assign lane_word[i] = 2'(3 - (int'(cnt) * COLS_PER_CYCLE + i));
        assign lane_col[i]  = work[lane_word[i]];

        mix_column_unit #(.INV_OUT(INV_OUT)) u_mix (
            .col   (lane_col[i]),
            .inv   (inv_q),
            .mixed (lane_mix[i])
        );
    end

    always_comb begin
        work_nxt = work;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            work_nxt[lane_word[i]] = lane_mix[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            inv_q       <= MODE_FWD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            work        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        work       <= bus.in_data;
                        inv_q      <= bus.in_inv;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    if (cnt == CNT_W'(NCYC - 1)) begin
                        out_data_q  <= work_nxt;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule
